// File: rtl/tile_blitter_pkg.sv
`default_nettype none
// ==================================================================
// game_params : shared tile/screen geometry, key bit, FSM states
// rev 1.0
// ==================================================================
package game_params;

  localparam int TILE_W    = 32;
  localparam int TILE_H    = 32;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int TILE_ID_W = 6;
  localparam int ROM_AW    = 16;
  localparam int KEY_BIT   = 15;
  localparam int DST_AW    = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } blit_state_t;

  // Constant pitch multiply as a sum of shifted copies (640 -> y<<9 + y<<7).
  function automatic logic [DST_AW-1:0] pitch_mul(input logic [8:0] y, input int unsigned pitch);
    logic [DST_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DST_AW; i++) begin
      if (pitch[i]) acc = acc + (DST_AW'(y) << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_blitter_addr_gen.sv
`default_nettype none
// ==================================================================
// blit_addr_gen : tile row/col walker, frame-buffer address and clip
// rev 1.0
// ==================================================================
module blit_addr_gen #(
  parameter int TILE_W    = game_params::TILE_W,
  parameter int TILE_H    = game_params::TILE_H,
  parameter int SCREEN_W  = game_params::SCREEN_W,
  parameter int SCREEN_H  = game_params::SCREEN_H,
  parameter int TILE_ID_W = game_params::TILE_ID_W,
  parameter int ROM_AW    = game_params::ROM_AW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 step,
  input  logic [TILE_ID_W-1:0] tile_id,
  input  logic [9:0]           pos_x,
  input  logic [8:0]           pos_y,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [18:0]          pix_addr,
  output logic                 on_screen,
  output logic                 last_pix
);
  import game_params::*;

  localparam int CW = $clog2(TILE_W);
  localparam int RW = $clog2(TILE_H);

  logic [TILE_ID_W-1:0] tile_id_q, tile_id_d;
  logic [9:0]           pos_x_q, pos_x_d;
  logic [8:0]           pos_y_q, pos_y_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [18:0]          row_base_q, row_base_d;
  logic                 col_wrap;

  assign col_wrap = (col_q == CW'(TILE_W - 1));

  always_comb begin
    tile_id_d  = tile_id_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (load) begin
      tile_id_d  = tile_id;
      pos_x_d    = pos_x;
      pos_y_d    = pos_y;
      col_d      = '0;
      row_d      = '0;
      row_base_d = pitch_mul(pos_y, SCREEN_W) + 19'(pos_x);
    end else if (step) begin
      col_d = col_q + CW'(1);
      if (col_wrap) begin
        row_d      = row_q + RW'(1);
        row_base_d = row_base_q + 19'(SCREEN_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_id_q  <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      tile_id_q  <= tile_id_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  assign rom_addr = {tile_id_q, row_q, col_q};
  assign pix_addr = row_base_q + 19'(col_q);
  assign last_pix = col_wrap && (row_q == RW'(TILE_H - 1));

  // Widened sums so a tile hanging past the right/bottom edge never wraps back on-screen.
  assign on_screen = (({1'b0, pos_x_q} + 11'(col_q)) < 11'(SCREEN_W)) &&
                     (({1'b0, pos_y_q} + 10'(row_q)) < 10'(SCREEN_H));

endmodule
`default_nettype wire

// File: rtl/tile_blitter.sv
`default_nettype none
// ==================================================================
// tile_blitter : copies one tile from tile ROM into the frame buffer
// rev 1.0
// ==================================================================
module tile_blitter #(
  parameter int TILE_W    = game_params::TILE_W,
  parameter int TILE_H    = game_params::TILE_H,
  parameter int SCREEN_W  = game_params::SCREEN_W,
  parameter int SCREEN_H  = game_params::SCREEN_H,
  parameter int TILE_ID_W = game_params::TILE_ID_W,
  parameter int ROM_AW    = game_params::ROM_AW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [TILE_ID_W-1:0] tile_id,
  input  logic [9:0]           pos_x,
  input  logic [8:0]           pos_y,
  output logic                 busy,
  output logic                 done,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [15:0]          rom_data,
  output logic [18:0]          dst_addr,
  output logic [15:0]          dst_data,
  output logic                 dst_wr
);
  import game_params::*;

  blit_state_t state_q, state_d;
  logic        accept, step, last_pix, on_screen;
  logic [18:0] pix_addr;
  logic        issued_q, issued_d;
  logic        on_screen_q, on_screen_d;
  logic [18:0] dst_addr_q, dst_addr_d;

  assign accept = (state_q == ST_IDLE) && start;
  assign step   = (state_q == ST_STREAM);

  blit_addr_gen #(
    .TILE_W    (TILE_W),
    .TILE_H    (TILE_H),
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .TILE_ID_W (TILE_ID_W),
    .ROM_AW    (ROM_AW)
  ) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .step      (step),
    .tile_id   (tile_id),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .rom_addr  (rom_addr),
    .pix_addr  (pix_addr),
    .on_screen (on_screen),
    .last_pix  (last_pix)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (last_pix) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pixel attributes travel one stage so they line up with the ROM read latency.
  always_comb begin
    issued_d    = step;
    on_screen_d = on_screen;
    dst_addr_d  = pix_addr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      issued_q    <= 1'b0;
      on_screen_q <= 1'b0;
      dst_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      on_screen_q <= on_screen_d;
      dst_addr_q  <= dst_addr_d;
    end
  end

  assign busy     = step || (state_q == ST_FLUSH);
  assign done     = (state_q == ST_DONE);
  assign dst_wr   = issued_q && on_screen_q && !rom_data[KEY_BIT];
  assign dst_addr = dst_addr_q;
  assign dst_data = issued_q ? rom_data : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_tile_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ==================================================================
// tb_tile_blitter : scoreboard bench for tile_blitter
// rev 1.0
// ==================================================================
module tb_tile_blitter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [5:0]  tile_id;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        busy, done;
  logic [15:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic [18:0] dst_addr;
  logic [15:0] dst_data;
  logic        dst_wr;

  always #5 clk = ~clk;

  tile_blitter dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .tile_id  (tile_id),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .dst_addr (dst_addr),
    .dst_data (dst_data),
    .dst_wr   (dst_wr)
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mode  = 0;
  int   wr_cnt, first_addr, last_addr, max_addr;
  bit   first_seen;

  // Tile ROM contents: 0 = flat 0x0ABC, 1 = checkerboard key, other = opaque address pattern.
  function automatic logic [15:0] rom_word(input int md, input logic [15:0] a);
    case (md)
      0:       return 16'h0ABC;
      1:       return {a[5] ^ a[0], 3'b000, a[11:0]};
      default: return {4'h0, a[11:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_word(mode, rom_addr);

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (dst_wr === 1'b1) begin
        wr_cnt++;
        last_addr = int'(dst_addr);
        if (!first_seen) begin
          first_seen = 1'b1;
          first_addr = int'(dst_addr);
        end
        if (int'(dst_addr) > max_addr) max_addr = int'(dst_addr);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write at cycle %0d",
                   dst_addr, dst_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(dst_addr), e.addr);
          chk("wr_data", 32'(dst_data), 32'(e.data));
        end
      end
    end
  end

  task automatic model(input logic [5:0] tid, input logic [9:0] px, input logic [8:0] py, input int md);
    exp_t        e;
    logic [15:0] a, w;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        if (int'(px) + c < 640 && int'(py) + r < 480) begin
          a = {tid, r[4:0], c[4:0]};
          w = rom_word(md, a);
          if (!w[15]) begin
            e.addr = (int'(py) + r) * 640 + int'(px) + c;
            e.data = w;
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic launch(input logic [5:0] tid, input logic [9:0] px, input logic [8:0] py,
                        input int md, output int t0);
    @(negedge clk);
    wr_cnt = 0; first_seen = 1'b0; first_addr = -1; last_addr = -1; max_addr = -1;
    mode = md; tile_id = tid; pos_x = px; pos_y = py; start = 1'b1;
    t0 = cyc;
    chk("busy_before", 32'(busy), 0);
    chk("done_low", 32'(done), 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    // Mid-blit input changes must not disturb the latched request.
    tile_id = ~tid; pos_x = px + 10'd3; pos_y = py + 9'd1;
  endtask

  task automatic finish_blit(input int t0, input bit poke, input int exp_n);
    int n;
    n = cyc - t0;
    while (done !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n = cyc - t0;
      start = (poke && n == 5);
    end
    chk("done_seen", 32'(done), 1);
    if (done === 1'b1) chk("done_time", n, 1026);
    else exp_q.delete();
    chk("busy_at_done", 32'(busy), 0);
    chk("write_count", wr_cnt, exp_n);
    chk("queue_drained", exp_q.size(), 0);
    if (poke) begin
      start = 1'b1; tile_id = 6'd9; pos_x = 10'd5; pos_y = 9'd5;
    end
  endtask

  task automatic blit(input logic [5:0] tid, input logic [9:0] px, input logic [8:0] py,
                      input int md, input bit poke, input int exp_n);
    int t0;
    model(tid, px, py, md);
    launch(tid, px, py, md, t0);
    finish_blit(t0, poke, exp_n);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin : stim
    int t0;
    rstn = 1'b0; start = 1'b0; tile_id = '0; pos_x = '0; pos_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr", 32'(dst_wr), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_dst_addr", 32'(dst_addr), 0);
    chk("rst_dst_data", 32'(dst_data), 0);
    rstn = 1'b1;

    blit(6'd3, 10'd0, 9'd0, 0, 1'b0, 1024);
    chk("basic_first", first_addr, 0);
    chk("basic_last", last_addr, 19871);

    blit(6'd7, 10'd100, 9'd50, 1, 1'b0, 512);
    chk("transp_first", first_addr, 32100);

    blit(6'd12, 10'd620, 9'd470, 2, 1'b0, 200);
    chk("clip_max", max_addr, 307199);

    blit(6'd1, 10'd700, 9'd400, 0, 1'b0, 0);

    blit(6'd3, 10'd0, 9'd0, 0, 1'b1, 1024);
    blit(6'd4, 10'd200, 9'd100, 2, 1'b0, 1024);
    chk("handshake_first", first_addr, 64200);

    model(6'd5, 10'd10, 9'd10, 2);
    launch(6'd5, 10'd10, 9'd10, 2, t0);
    while (cyc < t0 + 300) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wr", 32'(dst_wr), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_dst_addr", 32'(dst_addr), 0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_wr", 32'(dst_wr), 0);
      chk("rst_hold_done", 32'(done), 0);
    end
    rstn = 1'b1;

    blit(6'd3, 10'd0, 9'd0, 2, 1'b0, 1024);
    chk("post_rst_first", first_addr, 0);
    chk("post_rst_last", last_addr, 19871);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
